// File: rtl/shared_logic_arbiter.sv
// Two-requester round-robin arbiter in front of one registered bitwise unit.
// Define SHARED_LOGIC_XOR_EN to enable opcode 10 (XOR); otherwise it reports an error.
module shared_logic_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_opA,
  input  logic [WIDTH-1:0] req0_opB,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_opA,
  input  logic [WIDTH-1:0] req1_opB,
  input  logic [1:0]       req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_id,
  output logic             resp_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             id_q, id_d;
  logic             err_q, err_d;

  logic             slot_free;
  logic             grant;
  logic             accept;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;

  assign slot_free = (state_q == IDLE) || resp_ready;

  // On contention the requester not granted last wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_q;
    else                          grant = req1_valid;
  end

  assign req0_ready = !reset && slot_free && req0_valid && !grant;
  assign req1_ready = !reset && slot_free && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    sel_a  = grant ? req1_opA : req0_opA;
    sel_b  = grant ? req1_opB : req0_opB;
    sel_op = grant ? req1_op  : req0_op;
  end

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    unique case (sel_op)
      2'b00: alu_res = sel_a & sel_b;
      2'b01: alu_res = sel_a | sel_b;
`ifdef SHARED_LOGIC_XOR_EN
      2'b10: alu_res = sel_a ^ sel_b;
`else
      2'b10: alu_err = 1'b1;
`endif
      2'b11: alu_err = 1'b1;
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    result_d = result_q;
    id_d     = id_q;
    err_d    = err_q;
    if (accept) begin
      state_d  = HOLD;
      last_d   = grant;
      result_d = alu_res;
      id_d     = grant;
      err_d    = alu_err;
    end else if (state_q == HOLD && resp_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      result_q <= '0;
      id_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      result_q <= result_d;
      id_q     <= id_d;
      err_q    <= err_d;
    end
  end

  assign resp_valid  = (state_q == HOLD);
  assign resp_result = result_q;
  assign resp_id     = id_q;
  assign resp_err    = err_q;

endmodule
